// File: rtl/riscv_ahb3_ins_dat_arbiter_pkg.sv
// Shared AHB3 encodings and owner type for the instruction/data bus arbiter.
package riscv_ahb3_ins_dat_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        OWN_INS = 1'b0,
        OWN_DAT = 1'b1
    } owner_t;

    // A transfer that will produce a data phase once accepted.
    function automatic logic is_xfer(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

    // The owner is inside a locked sequence or a multi-beat burst and
    // must keep the address bus.
    function automatic logic must_hold(input logic [1:0] trans,
                                       input logic [2:0] burst,
                                       input logic       lock);
        return lock ||
               (trans == HTRANS_SEQ) ||
               (trans == HTRANS_BUSY) ||
               ((trans == HTRANS_NONSEQ) && (burst != HBURST_SINGLE));
    endfunction

endpackage

// File: rtl/riscv_ahb3_ins_dat_arbiter_if.sv
// AHB3 port bundle: master drives the request, slave drives the response.
interface riscv_ahb3_ins_dat_arbiter_if
    import riscv_ahb3_ins_dat_arbiter_pkg::*;
#(
    parameter int PLEN = 64,
    parameter int XLEN = 64
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/riscv_ahb3_ins_dat_arbiter.sv
// Two-master (instruction/data) to one-slave AHB3 arbiter with parked,
// round-robin grant, burst/lock hold and data-phase response routing.
module riscv_ahb3_ins_dat_arbiter
    import riscv_ahb3_ins_dat_arbiter_pkg::*;
#(
    parameter int PLEN        = 64,
    parameter int XLEN        = 64,
    parameter int RESET_OWNER = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    riscv_ahb3_ins_dat_arbiter_if.slave  ins,
    riscv_ahb3_ins_dat_arbiter_if.slave  dat,
    riscv_ahb3_ins_dat_arbiter_if.master bus
);

    localparam owner_t RST_OWNER = (RESET_OWNER != 0) ? OWN_DAT : OWN_INS;

    owner_t          addr_owner;
    owner_t          addr_owner_nxt;
    owner_t          data_owner;
    logic            data_active;

    logic            own_sel;
    logic [PLEN-1:0] own_haddr;
    logic            own_write;
    logic [2:0]      own_size;
    logic [2:0]      own_burst;
    logic [3:0]      own_prot;
    logic [1:0]      own_trans;
    logic            own_lock;
    logic [1:0]      other_trans;
    logic [XLEN-1:0] own_wdata;

    logic            ins_in_data;
    logic            dat_in_data;

    // Select the address-phase signals of the current address owner.
    always_comb begin
        if (addr_owner == OWN_INS) begin
            own_sel     = ins.HSEL;
            own_haddr   = ins.HADDR;
            own_write   = ins.HWRITE;
            own_size    = ins.HSIZE;
            own_burst   = ins.HBURST;
            own_prot    = ins.HPROT;
            own_trans   = ins.HTRANS;
            own_lock    = ins.HMASTLOCK;
            other_trans = dat.HTRANS;
        end else begin
            own_sel     = dat.HSEL;
            own_haddr   = dat.HADDR;
            own_write   = dat.HWRITE;
            own_size    = dat.HSIZE;
            own_burst   = dat.HBURST;
            own_prot    = dat.HPROT;
            own_trans   = dat.HTRANS;
            own_lock    = dat.HMASTLOCK;
            other_trans = ins.HTRANS;
        end
    end

    // Write data follows the master whose transfer is in its data phase.
    always_comb begin
        own_wdata = (data_owner == OWN_INS) ? ins.HWDATA : dat.HWDATA;
    end

    // Grant decision at a transfer boundary: keep bursts and locked
    // sequences together, otherwise hand over to a waiting master.
    always_comb begin
        addr_owner_nxt = addr_owner;
        if (bus.HREADY && !must_hold(own_trans, own_burst, own_lock) &&
            (other_trans != HTRANS_IDLE)) begin
            addr_owner_nxt = (addr_owner == OWN_INS) ? OWN_DAT : OWN_INS;
        end
    end

    // Ownership state advances only when the bus accepts the current beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_owner  <= RST_OWNER;
            data_owner  <= RST_OWNER;
            data_active <= 1'b0;
        end else if (bus.HREADY) begin
            addr_owner  <= addr_owner_nxt;
            data_owner  <= addr_owner;
            data_active <= is_xfer(own_trans);
        end
    end

    // Drive the shared bus; control is forced quiet while in reset.
    always_comb begin
        bus.HADDR     = own_haddr;
        bus.HWRITE    = own_write;
        bus.HSIZE     = own_size;
        bus.HBURST    = own_burst;
        bus.HPROT     = own_prot;
        bus.HWDATA    = own_wdata;
        bus.HSEL      = rst ? own_sel   : 1'b0;
        bus.HTRANS    = rst ? own_trans : HTRANS_IDLE;
        bus.HMASTLOCK = rst ? own_lock  : 1'b0;
    end

    // Route responses: the data-phase owner and the address owner see the
    // bus HREADY, a waiting master is stalled, an idle master sees ready.
    always_comb begin
        ins_in_data = data_active && (data_owner == OWN_INS);
        dat_in_data = data_active && (data_owner == OWN_DAT);

        ins.HRDATA = bus.HRDATA;
        dat.HRDATA = bus.HRDATA;

        if (!rst) begin
            ins.HREADY = 1'b1;
            dat.HREADY = 1'b1;
            ins.HRESP  = HRESP_OKAY;
            dat.HRESP  = HRESP_OKAY;
        end else begin
            if (ins_in_data || (addr_owner == OWN_INS)) begin
                ins.HREADY = bus.HREADY;
            end else begin
                ins.HREADY = (ins.HTRANS == HTRANS_IDLE);
            end
            if (dat_in_data || (addr_owner == OWN_DAT)) begin
                dat.HREADY = bus.HREADY;
            end else begin
                dat.HREADY = (dat.HTRANS == HTRANS_IDLE);
            end
            ins.HRESP = ins_in_data ? bus.HRESP : HRESP_OKAY;
            dat.HRESP = dat_in_data ? bus.HRESP : HRESP_OKAY;
        end
    end

endmodule

// File: tb/tb_riscv_ahb3_ins_dat_arbiter.sv
// Directed and randomized bench for the instruction/data AHB3 arbiter,
// checked every cycle against a transaction-level ownership model.
module tb_riscv_ahb3_ins_dat_arbiter;
    import riscv_ahb3_ins_dat_arbiter_pkg::*;

    localparam int PLEN = 64;
    localparam int XLEN = 64;
    localparam int RESET_OWNER = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_ahb3_ins_dat_arbiter_if #(.PLEN(PLEN), .XLEN(XLEN)) ins_if ();
    riscv_ahb3_ins_dat_arbiter_if #(.PLEN(PLEN), .XLEN(XLEN)) dat_if ();
    riscv_ahb3_ins_dat_arbiter_if #(.PLEN(PLEN), .XLEN(XLEN)) bus_if ();

    riscv_ahb3_ins_dat_arbiter #(
        .PLEN(PLEN), .XLEN(XLEN), .RESET_OWNER(RESET_OWNER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ins(ins_if),
        .dat(dat_if),
        .bus(bus_if)
    );

    typedef struct packed {
        logic        sel;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [1:0]  trans;
        logic        lock;
    } req_t;

    int vectors = 0;
    int miscompares = 0;

    // Model state: which master (0=ins, 1=dat) owns the address bus, which
    // one's beat is in its data phase, and whether that beat is real.
    int m_ao, m_do, m_da;

    function automatic req_t get_req(input int who);
        req_t r;
        if (who == 0) begin
            r.sel = ins_if.HSEL;   r.addr = ins_if.HADDR;  r.wdata = ins_if.HWDATA;
            r.write = ins_if.HWRITE; r.size = ins_if.HSIZE; r.burst = ins_if.HBURST;
            r.prot = ins_if.HPROT; r.trans = ins_if.HTRANS; r.lock = ins_if.HMASTLOCK;
        end else begin
            r.sel = dat_if.HSEL;   r.addr = dat_if.HADDR;  r.wdata = dat_if.HWDATA;
            r.write = dat_if.HWRITE; r.size = dat_if.HSIZE; r.burst = dat_if.HBURST;
            r.prot = dat_if.HPROT; r.trans = dat_if.HTRANS; r.lock = dat_if.HMASTLOCK;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [1:0] trans, input logic [2:0] burst,
                           input logic [63:0] addr, input logic lock);
        if (who == 0) begin
            ins_if.HTRANS = trans; ins_if.HBURST = burst; ins_if.HADDR = addr;
            ins_if.HMASTLOCK = lock; ins_if.HSEL = (trans != HTRANS_IDLE);
            ins_if.HWDATA = {$urandom, $urandom};
        end else begin
            dat_if.HTRANS = trans; dat_if.HBURST = burst; dat_if.HADDR = addr;
            dat_if.HMASTLOCK = lock; dat_if.HSEL = (trans != HTRANS_IDLE);
            dat_if.HWDATA = {$urandom, $urandom};
            dat_if.HWRITE = 1'b1;
        end
    endtask

    task automatic set_bus(input logic rdy, input logic resp);
        bus_if.HREADY = rdy;
        bus_if.HRESP  = resp;
        bus_if.HRDATA = {$urandom, $urandom};
    endtask

    // Full output check against the model, then advance the model at the edge.
    task automatic cycle();
        req_t r [2];
        req_t o;
        logic rdy_obs [2];
        logic rsp_obs [2];
        logic in_data;
        logic exp_rdy;
        logic cur_rst, cur_rdy;
        @(negedge clk);
        r[0] = get_req(0);
        r[1] = get_req(1);
        o = r[m_ao];
        cur_rst = rst;
        cur_rdy = bus_if.HREADY;
        chk("bus_HADDR",     bus_if.HADDR,     o.addr);
        chk("bus_HWRITE",    bus_if.HWRITE,    o.write);
        chk("bus_HSIZE",     bus_if.HSIZE,     o.size);
        chk("bus_HBURST",    bus_if.HBURST,    o.burst);
        chk("bus_HPROT",     bus_if.HPROT,     o.prot);
        chk("bus_HSEL",      bus_if.HSEL,      cur_rst ? o.sel : 1'b0);
        chk("bus_HTRANS",    bus_if.HTRANS,    cur_rst ? o.trans : 2'b00);
        chk("bus_HMASTLOCK", bus_if.HMASTLOCK, cur_rst ? o.lock : 1'b0);
        chk("bus_HWDATA",    bus_if.HWDATA,    r[m_do].wdata);
        chk("ins_HRDATA",    ins_if.HRDATA,    bus_if.HRDATA);
        chk("dat_HRDATA",    dat_if.HRDATA,    bus_if.HRDATA);
        rdy_obs[0] = ins_if.HREADY; rdy_obs[1] = dat_if.HREADY;
        rsp_obs[0] = ins_if.HRESP;  rsp_obs[1] = dat_if.HRESP;
        for (int x = 0; x < 2; x++) begin
            in_data = (m_da != 0) && (m_do == x);
            if (!cur_rst)                 exp_rdy = 1'b1;
            else if (in_data || m_ao == x) exp_rdy = cur_rdy;
            else                          exp_rdy = (r[x].trans == HTRANS_IDLE);
            chk(x == 0 ? "ins_HREADY" : "dat_HREADY", rdy_obs[x], exp_rdy);
            chk(x == 0 ? "ins_HRESP" : "dat_HRESP", rsp_obs[x],
                (cur_rst && in_data) ? bus_if.HRESP : 1'b0);
        end
        @(posedge clk);
        if (!cur_rst) begin
            m_ao = RESET_OWNER; m_do = RESET_OWNER; m_da = 0;
        end else if (cur_rdy) begin
            // Owner keeps the bus through bursts and locks; otherwise a
            // waiting master takes the next address slot.
            m_do = m_ao;
            m_da = (o.trans == HTRANS_NONSEQ || o.trans == HTRANS_SEQ) ? 1 : 0;
            if (!(o.lock || o.trans == HTRANS_SEQ || o.trans == HTRANS_BUSY ||
                  (o.trans == HTRANS_NONSEQ && o.burst != HBURST_SINGLE)) &&
                r[1 - m_ao].trans != HTRANS_IDLE)
                m_ao = 1 - m_ao;
        end
        #1;
    endtask

    task automatic idle_all();
        set_req(0, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
        set_req(1, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        ins_if.HWRITE = 1'b0; ins_if.HSIZE = 3'd3; ins_if.HPROT = 4'h3;
        dat_if.HWRITE = 1'b1; dat_if.HSIZE = 3'd3; dat_if.HPROT = 4'h1;
        idle_all();
        set_bus(1'b1, 1'b0);
        @(posedge clk);
        m_ao = RESET_OWNER; m_do = RESET_OWNER; m_da = 0;
        #1;

        // Reset held: control outputs forced quiet.
        dat_if.HTRANS = HTRANS_NONSEQ;
        #1;
        chk("rst_bus_HTRANS", bus_if.HTRANS, HTRANS_IDLE);
        chk("rst_dat_HREADY", dat_if.HREADY, 1'b1);
        cycle();
        idle_all();
        rst = 1'b1;

        // Parked instruction owner: zero-latency single read.
        set_req(0, HTRANS_NONSEQ, HBURST_SINGLE, 64'h200, 1'b0);
        #1;
        chk("park_bus_HADDR", bus_if.HADDR, 64'h200);
        chk("park_dat_HREADY", dat_if.HREADY, 1'b1);
        cycle();
        idle_all();
        set_bus(1'b1, 1'b0);
        cycle();

        // Both masters issue singles continuously: 1:1 alternation.
        for (int i = 0; i < 8; i++) begin
            set_req(0, HTRANS_NONSEQ, HBURST_SINGLE, 64'h1000, 1'b0);
            set_req(1, HTRANS_NONSEQ, HBURST_SINGLE, 64'h8000, 1'b0);
            set_bus(1'b1, 1'b0);
            #1;
            chk("alt_bus_HADDR", bus_if.HADDR, (i % 2 == 0) ? 64'h1000 : 64'h8000);
            cycle();
        end

        // Data INCR4 write burst while instruction waits.
        set_req(0, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
        set_req(1, HTRANS_NONSEQ, HBURST_INCR4, 64'h40, 1'b0);
        cycle();
        for (int b = 0; b < 4; b++) begin
            set_req(0, HTRANS_NONSEQ, HBURST_SINGLE, 64'h1000, 1'b0);
            set_req(1, b == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4,
                    64'h40 + 64'(8 * b), 1'b0);
            #1;
            chk("incr4_bus_HADDR", bus_if.HADDR, 64'h40 + 64'(8 * b));
            chk("incr4_ins_HREADY", ins_if.HREADY, 1'b0);
            cycle();
        end
        set_req(1, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
        cycle();
        set_req(0, HTRANS_NONSEQ, HBURST_SINGLE, 64'h1000, 1'b0);
        #1;
        chk("incr4_handover_HADDR", bus_if.HADDR, 64'h1000);
        cycle();

        // Locked pair of data singles keeps instruction out.
        set_req(0, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
        set_req(1, HTRANS_NONSEQ, HBURST_SINGLE, 64'h100, 1'b1);
        cycle();
        for (int k = 0; k < 2; k++) begin
            set_req(0, HTRANS_NONSEQ, HBURST_SINGLE, 64'h3000, 1'b0);
            set_req(1, HTRANS_NONSEQ, HBURST_SINGLE, 64'h100 + 64'(8 * k), 1'b1);
            #1;
            chk("lock_bus_HADDR", bus_if.HADDR, 64'h100 + 64'(8 * k));
            chk("lock_ins_HREADY", ins_if.HREADY, 1'b0);
            cycle();
        end
        set_req(1, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
        cycle();
        set_req(1, HTRANS_NONSEQ, HBURST_SINGLE, 64'h8000, 1'b0);
        #1;
        chk("unlock_bus_HADDR", bus_if.HADDR, 64'h3000);
        cycle();

        // Wait states on the instruction data phase, data address pending.
        set_req(0, HTRANS_IDLE, HBURST_SINGLE, 64'h0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            set_bus(1'b0, 1'b0);
            #1;
            chk("wait_bus_HADDR", bus_if.HADDR, 64'h8000);
            chk("wait_ins_HREADY", ins_if.HREADY, 1'b0);
            chk("wait_dat_HREADY", dat_if.HREADY, 1'b0);
            cycle();
        end
        set_bus(1'b1, 1'b0);
        cycle();

        // Two-cycle error on the data data-phase.
        idle_all();
        set_bus(1'b0, 1'b1);
        #1;
        chk("err1_dat_HRESP", dat_if.HRESP, 1'b1);
        chk("err1_ins_HRESP", ins_if.HRESP, 1'b0);
        cycle();
        set_bus(1'b1, 1'b1);
        #1;
        chk("err2_dat_HRESP", dat_if.HRESP, 1'b1);
        chk("err2_ins_HRESP", ins_if.HRESP, 1'b0);
        cycle();

        // Instruction INCR8 interrupted by reset on beat 3.
        set_bus(1'b1, 1'b0);
        set_req(0, HTRANS_NONSEQ, HBURST_INCR8, 64'h2000, 1'b0);
        cycle();
        for (int b = 0; b < 4; b++) begin
            set_req(0, b == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR8,
                    64'h2000 + 64'(8 * b), 1'b0);
            set_req(1, HTRANS_NONSEQ, HBURST_SINGLE, 64'h9000, 1'b0);
            if (b == 3) begin
                rst = 1'b0;
                #1;
                chk("midrst_bus_HTRANS", bus_if.HTRANS, HTRANS_IDLE);
                chk("midrst_ins_HREADY", ins_if.HREADY, 1'b1);
            end
            cycle();
        end
        rst = 1'b1;
        set_req(0, HTRANS_NONSEQ, HBURST_SINGLE, 64'h4000, 1'b0);
        set_req(1, HTRANS_NONSEQ, HBURST_SINGLE, 64'h9000, 1'b0);
        set_bus(1'b1, 1'b1);
        #1;
        chk("post_rst_bus_HADDR", bus_if.HADDR, 64'h4000);
        chk("post_rst_dat_HREADY", dat_if.HREADY, 1'b0);
        chk("post_rst_ins_HRESP", ins_if.HRESP, 1'b0);
        cycle();
        #1;
        chk("post_rst_next_HADDR", bus_if.HADDR, 64'h9000);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom % 40) != 0;
            for (int who = 0; who < 2; who++) begin
                set_req(who, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                        {$urandom, $urandom}, ($urandom % 5) == 0);
            end
            ins_if.HPROT = 4'($urandom); dat_if.HSIZE = 3'($urandom);
            set_bus(($urandom % 4) != 0, ($urandom % 6) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
